pl_mem_access: RTL and testbench

- Memory-stage load/store unit of the five-stage pipeline.
- Takes the M-stage address, store data and funct3, and runs a req/ready handshake with the external data memory.
- Returns the sign/zero-extended load value on ReadDataM, which the memory|writeback register captures.
- Drives StallM, the active-high hold input of all pipeline registers up to and including memory|writeback, so the W stage only sees a load result once the bus has completed.

---
 rtl/pl_mem_access.sv | 185 ++++++++++++++++++
 tb/tb_pl_mem_access.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_mem_access.sv
// rtl/pl_mem_access.sv - memory-stage load/store unit with req/ready data bus handshake
// Holds the pipeline via StallM until the bus access completes or times out.
module pl_mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        StallExtM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemFaultM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);
    localparam logic        LP_TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_buserr;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic [1:0]  w_a;
    logic        w_ld_fault;
    logic        w_st_fault;
    logic        w_acc;
    logic [15:0] w_cnt_next;
    logic        w_timeout;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    assign w_a = ALUResultM[1:0];

    always_comb begin
        w_ld_fault = 1'b1;
        w_st_fault = 1'b1;
        case (funct3M)
            3'b000, 3'b100: w_ld_fault = 1'b0;
            3'b001, 3'b101: w_ld_fault = w_a[0];
            3'b010:         w_ld_fault = |w_a;
            default:        w_ld_fault = 1'b1;
        endcase
        case (funct3M)
            3'b000:  w_st_fault = 1'b0;
            3'b001:  w_st_fault = w_a[0];
            3'b010:  w_st_fault = |w_a;
            default: w_st_fault = 1'b1;
        endcase
    end

    assign MemFaultM = (MemReadM & w_ld_fault) | (MemWriteM & w_st_fault);
    assign w_acc     = (MemReadM | MemWriteM) & ~MemFaultM;
    assign StallM    = (r_state == S_BUSY) | ((r_state == S_IDLE) & w_acc);

    always_comb begin
        w_st_wdata = WriteDataM;
        w_st_wstrb = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                w_st_wdata = {4{WriteDataM[7:0]}};
                w_st_wstrb = 4'b0001 << w_a;
            end
            2'b01: begin
                w_st_wdata = {2{WriteDataM[15:0]}};
                w_st_wstrb = 4'b0011 << w_a;
            end
            default: begin
                w_st_wdata = WriteDataM;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load formatting uses the funct3/offset latched at issue, not the live inputs.
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_fmt = mem_rdata;
        case (r_f3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    assign w_cnt_next = r_cnt + 16'd1;
    assign w_timeout  = LP_TO_EN && (w_cnt_next == LP_TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_f3     <= 3'd0;
            r_off    <= 2'd0;
            r_rdata  <= 32'd0;
            r_buserr <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWriteM;
                        r_addr  <= {ALUResultM[31:2], 2'b00};
                        r_wdata <= w_st_wdata;
                        r_wstrb <= MemWriteM ? w_st_wstrb : 4'd0;
                        r_f3    <= funct3M;
                        r_off   <= w_a;
                        r_cnt   <= 16'd0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_load_fmt;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout) begin
                            r_req    <= 1'b0;
                            r_rdata  <= 32'd0;
                            r_buserr <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!StallExtM) begin
                        r_buserr <= 1'b0;
                        r_cnt    <= 16'd0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ReadDataM = r_rdata;
    assign BusErrM   = r_buserr;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
endmodule

// File: tb/tb_pl_mem_access.sv
// tb/tb_pl_mem_access.sv - self-checking bench for pl_mem_access against a transaction timeline model
module tb_pl_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, StallExtM, mem_ready;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, mem_rdata;
    logic [31:0] ReadDataM, mem_addr, mem_wdata;
    logic        StallM, MemFaultM, BusErrM, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    pl_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallExtM(StallExtM), .ReadDataM(ReadDataM), .StallM(StallM),
        .MemFaultM(MemFaultM), .BusErrM(BusErrM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic        exp_stall, exp_fault, exp_req, exp_buserr, exp_we;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] seen_wdata, seen_addr;
    logic [3:0]  seen_wstrb;
    logic        seen_we;
    int          stall_base, req_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        if (!rd && !wr) return 1'b0;
        if (wr && f3[2]) return 1'b1;
        if (sz == 0) return 1'b1;
        return (int'(addr[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic [31:0] s;
        s = d >> (8 * int'(a));
        case (f3)
            3'd0:    return 32'($signed(s[7:0]));
            3'd4:    return s & 32'h0000_00FF;
            3'd1:    return 32'($signed(s[15:0]));
            3'd5:    return s & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        m = 4'((1 << m_size(f3)) - 1);
        return m << a;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("StallM", 32'(StallM), 32'(exp_stall));
            chk("MemFaultM", 32'(MemFaultM), 32'(exp_fault));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("BusErrM", 32'(BusErrM), 32'(exp_buserr));
            chk("ReadDataM", ReadDataM, exp_rd);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (StallM === 1'b1) stall_cnt++;
            if (mem_req === 1'b1) begin
                req_cnt++;
                seen_wdata = mem_wdata;
                seen_wstrb = mem_wstrb;
                seen_we    = mem_we;
                seen_addr  = mem_addr;
            end
        end
    end

    // One instruction in M: issue, wait states (or timeout), then DONE held by ext stalls.
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                      input int waitc, input int ext);
        logic timed;
        @(posedge clk); #1;
        stall_base = stall_cnt;
        req_base   = req_cnt;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        StallExtM = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
        exp_fault  = m_fault(rd, wr, f3, addr);
        exp_stall  = (rd | wr) & ~exp_fault;
        exp_req    = 1'b0;
        exp_buserr = 1'b0;
        if (!exp_stall) return;
        exp_addr  = {addr[31:2], 2'b00};
        exp_we    = wr;
        exp_wdata = m_wdata(f3, wd);
        exp_wstrb = wr ? m_wstrb(f3, addr[1:0]) : 4'd0;
        timed = (waitc >= TO);
        for (int i = 0; i <= waitc && i < TO; i++) begin
            @(posedge clk); #1;
            exp_req   = 1'b1;
            mem_ready = (i == waitc);
            mem_rdata = (i == waitc) ? rdv : $urandom;
        end
        for (int j = 0; j <= ext; j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                if (timed) exp_rd = 32'd0;
                else if (rd) exp_rd = m_load(rdv, f3, addr[1:0]);
            end
            exp_stall  = 1'b0;
            exp_req    = 1'b0;
            exp_buserr = timed;
            StallExtM  = (j < ext);
            mem_ready  = 1'($urandom);
            mem_rdata  = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            MemReadM = 1'b0; MemWriteM = 1'b0; StallExtM = 1'($urandom);
            mem_ready = 1'($urandom); mem_rdata = $urandom;
            exp_fault = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_buserr = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        int          kind;

        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; StallExtM = 1'b0; mem_ready = 1'b0;
        funct3M = 3'd0; ALUResultM = 32'd0; WriteDataM = 32'd0; mem_rdata = 32'd0;
        exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_buserr = 1'b0; exp_we = 1'b0;
        exp_rd = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        settle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ReadDataM", ReadDataM, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);

        op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        settle();
        chk("lw_stall_cycles", 32'(stall_cnt - stall_base), 32'd2);
        chk("lw_req_cycles", 32'(req_cnt - req_base), 32'd1);
        chk("lw_addr", seen_addr, 32'h100);
        chk("lw_wstrb", 32'(seen_wstrb), 32'd0);
        chk("lw_data", ReadDataM, 32'hDEADBEEF);

        op(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'h8077F0A5, 0, 1);
        settle(); chk("lb_data", ReadDataM, 32'hFFFFFF80);
        op(1'b1, 1'b0, 3'b100, 32'h201, 32'd0, 32'h8077F0A5, 1, 0);
        settle(); chk("lbu_data", ReadDataM, 32'h000000F0);
        op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h8077F0A5, 0, 0);
        settle(); chk("lhu_data", ReadDataM, 32'h00008077);
        op(1'b1, 1'b0, 3'b001, 32'h200, 32'd0, 32'h8077F0A5, 2, 0);
        settle(); chk("lh_data", ReadDataM, 32'hFFFFF0A5);

        op(1'b0, 1'b1, 3'b000, 32'h12, 32'h11223344, 32'd0, 0, 0);
        settle();
        chk("sb_wdata", seen_wdata, 32'h44444444);
        chk("sb_wstrb", 32'(seen_wstrb), 32'b0100);
        chk("sb_we", 32'(seen_we), 32'd1);
        op(1'b0, 1'b1, 3'b001, 32'h12, 32'h11223344, 32'd0, 0, 0);
        settle();
        chk("sh_wdata", seen_wdata, 32'h33443344);
        chk("sh_wstrb", 32'(seen_wstrb), 32'b1100);
        op(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'd0, 1, 0);
        settle();
        chk("sw_wstrb", 32'(seen_wstrb), 32'b1111);
        chk("store_keeps_rd", ReadDataM, 32'hFFFFF0A5);

        op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'h12345678, 3, 0);
        settle();
        chk("wait3_stall_cycles", 32'(stall_cnt - stall_base), 32'd5);
        chk("wait3_data", ReadDataM, 32'h12345678);

        op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 0);
        settle();
        chk("lw_mis_fault", 32'(MemFaultM), 32'd1);
        chk("lw_mis_req", 32'(req_cnt - req_base), 32'd0);
        op(1'b0, 1'b1, 3'b001, 32'h101, 32'hABCD, 32'd0, 0, 0);
        settle();
        chk("sh_mis_stall", 32'(stall_cnt - stall_base), 32'd0);
        op(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 0);
        settle();
        chk("ld_f3_011_fault", 32'(MemFaultM), 32'd1);
        chk("fault_keeps_rd", ReadDataM, 32'h12345678);

        op(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'hCAFEF00D, 10, 0);
        settle();
        chk("timeout_buserr", 32'(BusErrM), 32'd1);
        chk("timeout_rd", ReadDataM, 32'd0);
        chk("timeout_stall_cycles", 32'(stall_cnt - stall_base), 32'd5);
        idle(2);

        op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h55AA55AA, 0, 0);
        @(posedge clk); #1;
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h304;
        StallExtM = 1'b0; mem_ready = 1'b0;
        exp_fault = 1'b0; exp_stall = 1'b1; exp_req = 1'b0; exp_buserr = 1'b0;
        exp_addr = 32'h304; exp_we = 1'b0; exp_wstrb = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1; exp_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; MemReadM = 1'b0; mem_ready = 1'b1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rd = 32'd0;
        settle();
        chk("rst_busy_req", 32'(mem_req), 32'd0);
        chk("rst_busy_addr", mem_addr, 32'd0);
        chk("rst_busy_rd", ReadDataM, 32'd0);
        req_base = req_cnt;
        idle(5);
        settle();
        chk("rst_no_reissue", 32'(req_cnt - req_base), 32'd0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom % 8);
            rd = (kind >= 1 && kind <= 4);
            wr = (kind >= 5);
            f3 = 3'($urandom);
            op(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom % 6), int'($urandom % 3));
        end
        idle(2);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
